bus_master_if: RTL and testbench

Initiator-side bridge between the CPU memory stage and the 8-slave bus interconnect. Converts a single-cycle-presented CPU load/store request into a bus transaction: decodes the one-hot slave select from the address, holds address/data/select until the selected slave acks, and returns read data. Stalls the pipeline while the transaction is outstanding. Handles pipeline flush, aborts a transaction on timeout, and rejects unmapped addresses.

---
 rtl/bus_master_if.sv | 159 +++++++++++++++
 tb/tb_bus_master_if.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_if.sv
// bus_master_if
// Initiator-side bridge from the CPU memory stage to the 8-slave bus
// interconnect. It turns a one-cycle CPU load/store request into a bus
// transaction and holds it until the slave acks, a flush abandons it,
// or the timeout counter gives up on it. It stalls the pipeline while the
// transaction is outstanding.
//
// The slave index is the top address nibble. Slaves 0..7 are mapped.
// Slaves 8..15 are rejected with a one-cycle error pulse.
// All bus-side outputs are registered. The async reset drops an in-flight
// select immediately, without waiting for a clock edge.

module bus_master_if #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_ce_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_data_i,
   input  logic        cpu_stall_i,
   input  logic        flush_i,
   output logic [31:0] cpu_data_o,
   output logic        stallreq_o,
   output logic        err_o,
   output logic [31:0] bus_data_o,
   output logic [31:0] bus_addr_o,
   output logic        bus_we_o,
   output logic [15:0] bus_select_o,
   input  logic [31:0] bus_data_i,
   input  logic        bus_ack_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Last BUSY cycle index before the transaction is declared dead
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      rd_buf;
   logic             hold_read;

   logic [3:0]       idx;
   logic             mapped;
   logic [15:0]      dec_select;
   logic             in_idle;
   logic             in_busy;
   logic             in_hold;
   logic             start;
   logic             unmapped_err;
   logic             ack_take;
   logic             timeout_hit;

   assign idx     = cpu_addr_i[31:28];
   assign mapped  = ~idx[3];
   assign in_idle = (state == IDLE);
   assign in_busy = (state == BUSY);
   assign in_hold = (state == HOLD);

   // One-hot slave select for the mapped half of the address map
   always_comb begin
      dec_select = {8'h00, 8'h01 << idx[2:0]};
   end

   // Request and termination conditions seen in the current cycle.
   // A flush outranks an ack, and an ack outranks the timeout.
   always_comb begin
      start        = in_idle & cpu_ce_i & ~flush_i & mapped;
      unmapped_err = in_idle & cpu_ce_i & ~flush_i & ~mapped;
      ack_take     = in_busy & bus_ack_i & ~flush_i;
      timeout_hit  = in_busy & ~bus_ack_i & ~flush_i & (cnt == CNT_LAST);
   end

   // Stall and error go to the pipeline. They are forced low while reset
   // is held, so a request presented during reset produces nothing.
   always_comb begin
      stallreq_o = rst & (start | (in_busy & ~bus_ack_i & ~flush_i & ~timeout_hit));
      err_o      = rst & (unmapped_err | timeout_hit);
   end

   // Read data goes straight through in the ack cycle, then comes from the
   // buffer while the pipeline is held. A write always returns zero, even
   // if it is parked in HOLD.
   always_comb begin
      cpu_data_o = '0;
      if (rst) begin
         if (ack_take && !bus_we_o) begin
            cpu_data_o = bus_data_i;
         end else if (in_hold && hold_read) begin
            cpu_data_o = rd_buf;
         end
      end
   end

   // Transaction FSM. It owns all registered bus outputs, the timeout
   // counter and the read buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= '0;
         rd_buf       <= '0;
         hold_read    <= 1'b0;
         bus_addr_o   <= '0;
         bus_data_o   <= '0;
         bus_we_o     <= 1'b0;
         bus_select_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bus_addr_o   <= cpu_addr_i;
                  bus_data_o   <= cpu_data_i;
                  bus_we_o     <= cpu_we_i;
                  bus_select_o <= dec_select;
                  cnt          <= '0;
                  state        <= BUSY;
               end
            end
            BUSY: begin
               if (flush_i) begin
                  bus_select_o <= '0;
                  bus_we_o     <= 1'b0;
                  state        <= IDLE;
               end else if (bus_ack_i) begin
                  if (!bus_we_o) begin
                     rd_buf <= bus_data_i;
                  end
                  hold_read    <= ~bus_we_o;
                  bus_select_o <= '0;
                  bus_we_o     <= 1'b0;
                  state        <= cpu_stall_i ? HOLD : IDLE;
               end else if (cnt == CNT_LAST) begin
                  bus_select_o <= '0;
                  bus_we_o     <= 1'b0;
                  state        <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (!cpu_stall_i || flush_i) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if
// Self-checking bench for bus_master_if, built with TIMEOUT=4.
// It runs in three parts:
//   1. A table of hand-derived per-cycle vectors.
//   2. Randomized traffic compared against a transaction-level model.
//   3. An asynchronous reset applied mid-transaction.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// 5 time units after the edge, half a cycle away from it.

module tb_bus_master_if;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_ce_i;
   logic        cpu_we_i;
   logic [31:0] cpu_addr_i;
   logic [31:0] cpu_data_i;
   logic        cpu_stall_i;
   logic        flush_i;
   logic [31:0] cpu_data_o;
   logic        stallreq_o;
   logic        err_o;
   logic [31:0] bus_data_o;
   logic [31:0] bus_addr_o;
   logic        bus_we_o;
   logic [15:0] bus_select_o;
   logic [31:0] bus_data_i;
   logic        bus_ack_i;

   int checks = 0;
   int passes = 0;

   // Free-running clock, period 10
   always #5 clk = ~clk;

   bus_master_if #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_ce_i     (cpu_ce_i),
      .cpu_we_i     (cpu_we_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_data_i   (cpu_data_i),
      .cpu_stall_i  (cpu_stall_i),
      .flush_i      (flush_i),
      .cpu_data_o   (cpu_data_o),
      .stallreq_o   (stallreq_o),
      .err_o        (err_o),
      .bus_data_o   (bus_data_o),
      .bus_addr_o   (bus_addr_o),
      .bus_we_o     (bus_we_o),
      .bus_select_o (bus_select_o),
      .bus_data_i   (bus_data_i),
      .bus_ack_i    (bus_ack_i)
   );

   typedef struct {
      logic        ce, we, stall, flush, ack;
      logic [31:0] addr, wdata, rdata;
      logic        e_stall, e_err;
      logic [31:0] e_data;
      logic [15:0] e_sel;
      logic        e_we;
      logic        chk_bus;
      logic [31:0] e_addr, e_bdata;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic ce, logic we, logic [31:0] addr, logic [31:0] wdata,
                               logic stall, logic flush, logic ack, logic [31:0] rdata,
                               logic e_stall, logic e_err, logic [31:0] e_data,
                               logic [15:0] e_sel, logic e_we,
                               logic chk_bus, logic [31:0] e_addr, logic [31:0] e_bdata);
      vec_t v;
      v.ce = ce; v.we = we; v.addr = addr; v.wdata = wdata;
      v.stall = stall; v.flush = flush; v.ack = ack; v.rdata = rdata;
      v.e_stall = e_stall; v.e_err = e_err; v.e_data = e_data;
      v.e_sel = e_sel; v.e_we = e_we;
      v.chk_bus = chk_bus; v.e_addr = e_addr; v.e_bdata = e_bdata;
      return v;
   endfunction

   task automatic applyStimulus(input logic ce, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic stall, input logic flush,
                                input logic ack, input logic [31:0] rdata);
      cpu_ce_i    = ce;
      cpu_we_i    = we;
      cpu_addr_i  = addr;
      cpu_data_i  = wdata;
      cpu_stall_i = stall;
      flush_i     = flush;
      bus_ack_i   = ack;
      bus_data_i  = rdata;
   endtask

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   task automatic checkOutput(input string tag, input logic e_stall, input logic e_err,
                              input logic [31:0] e_data, input logic [15:0] e_sel,
                              input logic e_we, input logic chk_bus,
                              input logic [31:0] e_addr, input logic [31:0] e_bdata);
      checkVal({tag, " stallreq"}, 32'(stallreq_o), 32'(e_stall));
      checkVal({tag, " err"}, 32'(err_o), 32'(e_err));
      checkVal({tag, " cpu_data"}, cpu_data_o, e_data);
      checkVal({tag, " select"}, 32'(bus_select_o), 32'(e_sel));
      checkVal({tag, " bus_we"}, 32'(bus_we_o), 32'(e_we));
      if (chk_bus) begin
         checkVal({tag, " bus_addr"}, bus_addr_o, e_addr);
         checkVal({tag, " bus_data"}, bus_data_o, e_bdata);
      end
   endtask

   // Transaction-level reference model
   bit          m_pending;
   bit          m_holding;
   bit          m_held_read;
   int          m_waited;
   logic [31:0] m_rdbuf, m_addr, m_wdata;
   logic [15:0] m_sel;
   logic        m_we;

   task automatic modelReset();
      m_pending = 0; m_holding = 0; m_held_read = 0; m_waited = 0;
      m_rdbuf = '0; m_addr = '0; m_wdata = '0; m_sel = '0; m_we = 1'b0;
   endtask

   initial begin
      logic [15:0] one;
      logic        ce, we, stall, flush, ack, mapped, to;
      logic [31:0] addr, wdata, rdata;
      logic        e_stall, e_err;
      logic [31:0] e_data;
      one = 16'h0001;

      // Hand-derived per-cycle vectors
      // Read to slave 3, ack after 3 BUSY cycles
      vecs.push_back(mk(1,0,32'h3000_0010,0,0,0,0,0,            1,0,0,16'h0000,0, 1,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                        1,0,0,16'h0008,0, 1,32'h3000_0010,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                        1,0,0,16'h0008,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,1,32'hDEAD_BEEF,            0,0,32'hDEAD_BEEF,16'h0008,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                        0,0,0,16'h0000,0, 0,0,0));
      // Write to slave 7 with immediate ack, then a back-to-back read
      vecs.push_back(mk(1,1,32'h7000_0000,32'h1234_5678,0,0,0,0,1,0,0,16'h0000,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,1,32'hFFFF_FFFF,            0,0,0,16'h0080,1, 1,32'h7000_0000,32'h1234_5678));
      vecs.push_back(mk(1,0,32'h0000_0004,0,0,0,0,0,            1,0,0,16'h0000,0, 0,0,0));
      // Read ack while stalled, then held for 4 more cycles
      vecs.push_back(mk(0,0,0,0,1,0,1,32'hA5A5_0001,            0,0,32'hA5A5_0001,16'h0001,0, 1,32'h0000_0004,0));
      vecs.push_back(mk(0,0,0,0,1,0,0,0,                        0,0,32'hA5A5_0001,16'h0000,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,1,0,0,0,                        0,0,32'hA5A5_0001,16'h0000,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,1,0,0,0,                        0,0,32'hA5A5_0001,16'h0000,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,1,0,1,32'h1111_2222,            0,0,32'hA5A5_0001,16'h0000,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                        0,0,32'hA5A5_0001,16'h0000,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,1,32'hFFFF_0000,            0,0,0,16'h0000,0, 0,0,0));
      // Unmapped addresses
      vecs.push_back(mk(1,0,32'h9000_0000,0,0,0,0,0,            0,1,0,16'h0000,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                        0,0,0,16'h0000,0, 0,0,0));
      vecs.push_back(mk(1,1,32'hF000_0000,0,0,0,0,0,            0,1,0,16'h0000,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                        0,0,0,16'h0000,0, 0,0,0));
      // Timeout after 4 BUSY cycles
      vecs.push_back(mk(1,0,32'h2000_0000,0,0,0,0,0,            1,0,0,16'h0000,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                        1,0,0,16'h0004,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                        1,0,0,16'h0004,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                        1,0,0,16'h0004,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                        0,1,0,16'h0004,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                        0,0,0,16'h0000,0, 0,0,0));
      // Flush with ack in the 2nd BUSY cycle
      vecs.push_back(mk(1,0,32'h5000_0000,0,0,0,0,0,            1,0,0,16'h0000,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                        1,0,0,16'h0020,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,1,32'h1212_1212,            0,0,0,16'h0020,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                        0,0,0,16'h0000,0, 0,0,0));
      // Flush in IDLE suppresses a request
      vecs.push_back(mk(1,0,32'h5000_0000,0,0,1,0,0,            0,0,0,16'h0000,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                        0,0,0,16'h0000,0, 0,0,0));

      // Reset state
      applyStimulus(0,0,0,0,0,0,0,0);
      rst = 1'b0;
      #12;
      checkOutput("reset", 0,0,0,16'h0000,0, 1,0,0);
      rst = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                       vecs[i].stall, vecs[i].flush, vecs[i].ack, vecs[i].rdata);
         #4;
         checkOutput($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_err, vecs[i].e_data,
                     vecs[i].e_sel, vecs[i].e_we, vecs[i].chk_bus, vecs[i].e_addr, vecs[i].e_bdata);
         @(posedge clk); #1;
      end

      // Randomized traffic against the model
      applyStimulus(0,0,0,0,0,0,0,0);
      rst = 1'b0;
      #4;
      rst = 1'b1;
      modelReset();
      @(posedge clk); #1;
      for (int i = 0; i < 600; i++) begin
         ce    = ($urandom_range(0, 99) < 50);
         we    = 1'($urandom_range(0, 1));
         addr  = {4'($urandom_range(0, 11)), 28'($urandom)};
         wdata = $urandom;
         stall = ($urandom_range(0, 99) < 30);
         flush = ($urandom_range(0, 99) < 6);
         ack   = ($urandom_range(0, 99) < 30);
         rdata = $urandom;
         applyStimulus(ce, we, addr, wdata, stall, flush, ack, rdata);
         #4;
         mapped = (addr[31:28] < 4'd8);
         to     = 1'b0;
         if (m_holding) begin
            e_stall = 0; e_err = 0;
            e_data  = m_held_read ? m_rdbuf : 32'h0;
         end else if (m_pending) begin
            to      = !ack && !flush && (m_waited == TIMEOUT - 1);
            e_stall = !ack && !flush && !to;
            e_err   = to;
            e_data  = (ack && !flush && !m_we) ? rdata : 32'h0;
         end else begin
            e_stall = ce && !flush && mapped;
            e_err   = ce && !flush && !mapped;
            e_data  = 32'h0;
         end
         checkOutput($sformatf("rand%0d", i), e_stall, e_err, e_data, m_sel, m_we, 1, m_addr, m_wdata);
         // advance the model by one cycle
         if (m_holding) begin
            if (!stall || flush) m_holding = 0;
         end else if (m_pending) begin
            if (flush || ack || to) begin
               if (!flush && ack) begin
                  if (!m_we) m_rdbuf = rdata;
                  m_held_read = !m_we;
                  m_holding   = stall;
               end
               m_pending = 0; m_sel = '0; m_we = 1'b0;
            end else begin
               m_waited++;
            end
         end else if (ce && !flush && mapped) begin
            m_pending = 1; m_waited = 0;
            m_sel = one << addr[31:28];
            m_we = we; m_addr = addr; m_wdata = wdata;
         end
         @(posedge clk); #1;
      end

      // Asynchronous reset in the middle of a BUSY transaction
      applyStimulus(0,0,0,0,0,0,0,0);
      rst = 1'b0;
      #4;
      rst = 1'b1;
      @(posedge clk); #1;
      applyStimulus(1,0,32'h6000_0000,0,0,0,0,0);
      #4;
      checkOutput("rstmid req", 1,0,0,16'h0000,0, 0,0,0);
      @(posedge clk); #1;
      applyStimulus(0,0,0,0,0,0,0,0);
      #4;
      checkOutput("rstmid busy", 1,0,0,16'h0040,0, 1,32'h6000_0000,0);
      @(posedge clk); #1;
      #1;
      checkVal("rstmid select before reset", 32'(bus_select_o), 32'h0040);
      rst = 1'b0;
      #1;
      checkVal("rstmid async select", 32'(bus_select_o), 32'h0);
      checkVal("rstmid async stallreq", 32'(stallreq_o), 32'h0);
      checkVal("rstmid async addr", bus_addr_o, 32'h0);
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #1;
      applyStimulus(1,0,32'h1000_0008,0,0,0,0,0);
      #4;
      checkOutput("post req", 1,0,0,16'h0000,0, 0,0,0);
      @(posedge clk); #1;
      applyStimulus(0,0,0,0,0,0,0,0);
      #4;
      checkOutput("post busy", 1,0,0,16'h0002,0, 1,32'h1000_0008,0);
      @(posedge clk); #1;
      applyStimulus(0,0,0,0,0,0,1,32'hCAFE_F00D);
      #4;
      checkOutput("post ack", 0,0,32'hCAFE_F00D,16'h0002,0, 0,0,0);
      @(posedge clk); #1;
      applyStimulus(0,0,0,0,0,0,0,0);
      #4;
      checkOutput("post idle", 0,0,0,16'h0000,0, 0,0,0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
